// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one column driven low at a time, rows sampled
// through a two-flop synchronizer, press and release debounced, one KeyValid
// strobe per accepted press.
//
//  state        | meaning
//  -------------+------------------------------------------------------------
//  SCAN         | dwell on the current column, sample rows at end of dwell
//  DEBOUNCE     | column frozen, wait for the row pattern to stay stable
//  PRESSED      | single cycle: strobe KeyValid, register KeyCode
//  WAIT_RELEASE | column frozen, wait for all rows to stay released
module keypad_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       Clk,
   input  logic       ResetN,
   input  logic [3:0] Rows,
   output logic [3:0] Cols,
   output logic [3:0] KeyCode,
   output logic       KeyValid,
   output logic       KeyHeld
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      SCAN         = 2'd0,
      DEBOUNCE     = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   state_t        state, state_d;
   logic [3:0]    rs_meta, rs;
   logic [DW-1:0] dwell, dwell_d;
   logic [BW-1:0] deb, deb_d;
   logic [3:0]    pat, pat_d;
   logic [1:0]    col, col_d;
   logic [3:0]    code_d;
   logic          valid_d, held_d;

   // exactly one row low; anything else (idle or ghosting chord) is no key
   function automatic logic one_low(input logic [3:0] p);
      case (p)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
         default:                            one_low = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] low_row(input logic [3:0] p);
      case (p)
         4'b1101: low_row = 2'd1;
         4'b1011: low_row = 2'd2;
         4'b0111: low_row = 2'd3;
         default: low_row = 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
         4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
         4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
         4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
      endcase
   endfunction

   // column index 0 drives Cols[0]; advancing the index rotates the pattern left
   assign Cols = ~(4'b0001 << col);

   // two-flop synchronizer for the asynchronous row inputs
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         rs_meta <= 4'b1111;
         rs      <= 4'b1111;
      end else begin
         rs_meta <= Rows;
         rs      <= rs_meta;
      end
   end

   // state and datapath registers
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state    <= SCAN;
         dwell    <= '0;
         deb      <= '0;
         pat      <= 4'b1111;
         col      <= 2'd0;
         KeyCode  <= 4'h0;
         KeyValid <= 1'b0;
         KeyHeld  <= 1'b0;
      end else begin
         state    <= state_d;
         dwell    <= dwell_d;
         deb      <= deb_d;
         pat      <= pat_d;
         col      <= col_d;
         KeyCode  <= code_d;
         KeyValid <= valid_d;
         KeyHeld  <= held_d;
      end
   end

   // next-state and next-value logic
   always_comb begin
      state_d = state;
      dwell_d = dwell;
      deb_d   = deb;
      pat_d   = pat;
      col_d   = col;
      code_d  = KeyCode;
      valid_d = 1'b0;
      held_d  = KeyHeld;
      case (state)
         SCAN: begin
            if (dwell == DWELL_LAST) begin
               if (one_low(rs)) begin
                  pat_d   = rs;
                  deb_d   = '0;
                  state_d = DEBOUNCE;
               end else begin
                  col_d   = col + 2'd1;
                  dwell_d = '0;
               end
            end else begin
               dwell_d = dwell + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rs == pat) begin
               if (deb == DEB_LAST) begin
                  state_d = PRESSED;
                  valid_d = 1'b1;
                  code_d  = key_map(low_row(pat), col);
                  held_d  = 1'b1;
               end else begin
                  deb_d = deb + 1'b1;
               end
            end else if (one_low(rs)) begin
               pat_d = rs;
               deb_d = '0;
            end else begin
               state_d = SCAN;
               col_d   = col + 2'd1;
               dwell_d = '0;
            end
         end
         PRESSED: begin
            state_d = WAIT_RELEASE;
            deb_d   = '0;
         end
         WAIT_RELEASE: begin
            if (rs == 4'b1111) begin
               if (deb == DEB_LAST) begin
                  state_d = SCAN;
                  held_d  = 1'b0;
                  col_d   = col + 2'd1;
                  dwell_d = '0;
               end else begin
                  deb_d = deb + 1'b1;
               end
            end else begin
               deb_d = '0;
            end
         end
         default: state_d = SCAN;
      endcase
   end

endmodule
